// File: rtl/cpr_pkg.sv
// Shared types and defaults for the carry-propagate resolver.
// One pipeline entry carries its partial result plus the operands still to add.
package cpr_pkg;

    localparam int CPR_WIDTH  = 64;
    localparam int CPR_SEG    = 16;
    localparam int CPR_NSTAGE = CPR_WIDTH / CPR_SEG;
    localparam int CPR_TAGW   = 8;

    typedef struct packed {
        logic [CPR_WIDTH-1:0] res;
        logic                 cy;
        logic [CPR_TAGW-1:0]  tag;
        logic [CPR_WIDTH-1:0] sum;
        logic [CPR_WIDTH-1:0] car;
    } cpr_entry_t;

endpackage

// File: rtl/carry_propagate_resolver_seg_adder.sv
// Combinational SEG-bit adder with carry-in and carry-out.
// One instance resolves one segment in each pipeline stage.
module seg_adder #(
    parameter int SEG = 16
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};

endmodule

// File: rtl/carry_propagate_resolver.sv
// Elastic segmented pipeline turning a carry-save pair into a binary sum.
// Stage k resolves bits [k*SEG +: SEG]; bubbles collapse under backpressure.
module carry_propagate_resolver
    import cpr_pkg::*;
#(
    parameter int WIDTH = CPR_WIDTH,
    parameter int SEG   = CPR_SEG,
    parameter int TAGW  = CPR_TAGW
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_carry,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic [TAGW-1:0]  out_tag
);

    localparam int NSTAGE = WIDTH / SEG;

    cpr_entry_t        pipe_q [NSTAGE];
    cpr_entry_t        pipe_d [NSTAGE];
    cpr_entry_t        src    [NSTAGE];
    cpr_entry_t        calc   [NSTAGE];
    cpr_entry_t        in_ent;
    logic [NSTAGE-1:0] vld_q;
    logic [NSTAGE-1:0] vld_d;
    logic [NSTAGE-1:0] src_vld;
    logic [NSTAGE-1:0] adv;
    logic [SEG-1:0]    seg_s [NSTAGE];
    logic [NSTAGE-1:0] seg_c;
    logic              run_q;
    logic              run_d;
    logic              full_tail;

    // A stage may advance unless it and every stage after it is full
    // while the output is stalled; this avoids a serial ready chain.
    always_comb begin
        adv       = '0;
        full_tail = 1'b1;
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            full_tail = full_tail & vld_q[k];
            adv[k]    = out_ready | ~full_tail;
        end
    end

    assign in_ready = run_q & adv[0];

    always_comb begin
        in_ent                  = '0;
        in_ent.tag[TAGW-1:0]    = in_tag;
        in_ent.sum[WIDTH-1:0]   = in_sum;
        in_ent.car[WIDTH-1:0]   = in_carry;
    end

    always_comb begin
        src[0]     = in_ent;
        src_vld[0] = in_valid & in_ready;
        for (int k = 1; k < NSTAGE; k++) begin
            src[k]     = pipe_q[k-1];
            src_vld[k] = vld_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        seg_adder #(
            .SEG (SEG)
        ) u_add (
            .a  (src[k].sum[k*SEG +: SEG]),
            .b  (src[k].car[k*SEG +: SEG]),
            .ci (src[k].cy),
            .s  (seg_s[k]),
            .co (seg_c[k])
        );
    end

    always_comb begin
        run_d = 1'b1;
        vld_d = vld_q;
        for (int k = 0; k < NSTAGE; k++) begin
            calc[k]                    = src[k];
            calc[k].res[k*SEG +: SEG]  = seg_s[k];
            calc[k].cy                 = seg_c[k];
            pipe_d[k]                  = pipe_q[k];
            if (adv[k]) begin
                vld_d[k] = src_vld[k];
                if (src_vld[k]) begin
                    pipe_d[k] = calc[k];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_q <= 1'b0;
            vld_q <= '0;
            for (int k = 0; k < NSTAGE; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            run_q <= run_d;
            vld_q <= vld_d;
            for (int k = 0; k < NSTAGE; k++) begin
                pipe_q[k] <= pipe_d[k];
            end
        end
    end

    assign out_valid  = vld_q[NSTAGE-1];
    assign out_result = pipe_q[NSTAGE-1].res[WIDTH-1:0];
    assign out_cout   = pipe_q[NSTAGE-1].cy;
    assign out_tag    = pipe_q[NSTAGE-1].tag[TAGW-1:0];

endmodule

// File: tb/tb_carry_propagate_resolver.sv
// Directed bench for carry_propagate_resolver: latency, ripple, streaming,
// backpressure, async reset and a randomized handshake run with a scoreboard.
module tb_carry_propagate_resolver;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_sum;
    logic [63:0] in_carry;
    logic [7:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic        out_cout;
    logic [7:0]  out_tag;

    int checks   = 0;
    int failures = 0;

    carry_propagate_resolver dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sum     (in_sum),
        .in_carry   (in_carry),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_cout   (out_cout),
        .out_tag    (out_tag)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [63:0] sa [4];
    logic [63:0] sb [4];
    logic [63:0] sr [4];
    logic        sc [4];

    logic [63:0] ra [20];
    logic [63:0] rb [20];
    logic [64:0] rx [20];

    logic [64:0] q_res [$];
    logic [7:0]  q_tag [$];

    initial begin
        int          acc;
        bit          take;
        int          sent;
        int          got;
        bit          prev_stall;
        logic [63:0] prev_res;
        logic [7:0]  prev_tag;
        logic [64:0] e;
        logic [7:0]  et;

        sa[0] = 64'h0000_FFFF_0000_FFFF; sb[0] = 64'h0000_0001_0000_0001;
        sr[0] = 64'h0001_0000_0001_0000; sc[0] = 1'b0;
        sa[1] = 64'h8000_0000_0000_0000; sb[1] = 64'h8000_0000_0000_0000;
        sr[1] = 64'h0000_0000_0000_0000; sc[1] = 1'b1;
        sa[2] = 64'h1234_5678_9ABC_DEF0; sb[2] = 64'h0FED_CBA9_8765_4321;
        sr[2] = 64'h2222_2222_2222_2211; sc[2] = 1'b0;
        sa[3] = 64'hFFFF_0000_FFFF_0000; sb[3] = 64'h0001_0000_0001_0000;
        sr[3] = 64'h0000_0001_0000_0000; sc[3] = 1'b1;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        in_tag    = '0;
        out_ready = 1'b1;

        // reset state
        repeat (3) tick();
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd0);
        chk("rst_out_result", out_result, 64'd0);
        chk("rst_out_cout", {63'b0, out_cout}, 64'd0);
        chk("rst_out_tag", {56'b0, out_tag}, 64'd0);
        #3 reset_n = 1'b1;
        #1 chk("rdy_before_edge", {63'b0, in_ready}, 64'd0);
        tick();
        chk("rdy_after_edge", {63'b0, in_ready}, 64'd1);

        // single pair, 4-cycle latency
        in_valid = 1'b1;
        in_sum   = 64'h0000_0000_FFFF_FFFF;
        in_carry = 64'h0000_0000_0000_0001;
        in_tag   = 8'h11;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("lat_not_early", {63'b0, out_valid}, 64'd0);
        tick();
        chk("lat_valid", {63'b0, out_valid}, 64'd1);
        chk("lat_result", out_result, 64'h0000_0001_0000_0000);
        chk("lat_cout", {63'b0, out_cout}, 64'd0);
        chk("lat_tag", {56'b0, out_tag}, 64'h11);
        tick();
        chk("lat_drained", {63'b0, out_valid}, 64'd0);

        // full ripple through every segment
        in_valid = 1'b1;
        in_sum   = 64'hFFFF_FFFF_FFFF_FFFF;
        in_carry = 64'h1;
        in_tag   = 8'h22;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("rip_valid", {63'b0, out_valid}, 64'd1);
        chk("rip_result", out_result, 64'd0);
        chk("rip_cout", {63'b0, out_cout}, 64'd1);
        chk("rip_tag", {56'b0, out_tag}, 64'h22);
        tick();

        // back-to-back stream of 20
        for (int i = 0; i < 20; i++) begin
            ra[i] = {$urandom, $urandom};
            rb[i] = {$urandom, $urandom};
            rx[i] = {1'b0, ra[i]} + {1'b0, rb[i]};
        end
        for (int c = 0; c < 24; c++) begin
            in_valid = (c < 20);
            if (c < 20) begin
                in_sum   = ra[c];
                in_carry = rb[c];
                in_tag   = 8'(c + 8'h30);
                chk("str_in_ready", {63'b0, in_ready}, 64'd1);
            end
            tick();
            chk("str_out_valid", {63'b0, out_valid},
                {63'b0, (c >= 3 && c < 23)});
            if (c >= 3 && c < 23) begin
                chk("str_result", out_result, rx[c-3][63:0]);
                chk("str_cout", {63'b0, out_cout}, {63'b0, rx[c-3][64]});
                chk("str_tag", {56'b0, out_tag}, 64'(c - 3 + 8'h30));
            end
        end
        in_valid = 1'b0;

        // backpressure: 10 cycles with output stalled
        out_ready = 1'b0;
        acc = 0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1;
            in_sum   = sa[acc < 4 ? acc : 3];
            in_carry = sb[acc < 4 ? acc : 3];
            in_tag   = 8'(8'hA0 + acc);
            #1 take = in_ready;
            tick();
            if (take) acc++;
            if (c >= 3) chk("stall_hold", out_result, sr[0]);
        end
        in_valid = 1'b0;
        chk("stall_accepted", 64'(acc), 64'd4);
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
        out_ready = 1'b1;
        #1;
        for (int j = 0; j < 4; j++) begin
            chk("drain_valid", {63'b0, out_valid}, 64'd1);
            chk("drain_result", out_result, sr[j]);
            chk("drain_cout", {63'b0, out_cout}, {63'b0, sc[j]});
            chk("drain_tag", {56'b0, out_tag}, 64'(8'hA0 + j));
            tick();
        end
        chk("drain_empty", {63'b0, out_valid}, 64'd0);

        // async reset with 3 entries in flight
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            in_valid = 1'b1;
            in_sum   = sa[j];
            in_carry = sb[j];
            in_tag   = 8'(8'hC0 + j);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();
        chk("pre_rst_valid", {63'b0, out_valid}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_valid", {63'b0, out_valid}, 64'd0);
        chk("async_rst_ready", {63'b0, in_ready}, 64'd0);
        chk("async_rst_result", out_result, 64'd0);
        tick();
        #3 reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("post_rst_ready", {63'b0, in_ready}, 64'd1);
        for (int j = 0; j < 5; j++) begin
            chk("no_stale", {63'b0, out_valid}, 64'd0);
            tick();
        end
        in_valid = 1'b1;
        in_sum   = sa[2];
        in_carry = sb[2];
        in_tag   = 8'h5A;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        chk("post_rst_lat0", {63'b0, out_valid}, 64'd0);
        tick();
        chk("post_rst_valid", {63'b0, out_valid}, 64'd1);
        chk("post_rst_result", out_result, sr[2]);
        chk("post_rst_tag", {56'b0, out_tag}, 64'h5A);
        tick();

        // random handshakes against a scoreboard
        sent = 0;
        got = 0;
        prev_stall = 1'b0;
        prev_res = '0;
        prev_tag = '0;
        for (int cyc = 0; cyc < 20000 && got < 300; cyc++) begin
            in_valid  = (sent < 300) && ($urandom_range(0, 3) != 0);
            in_sum    = {$urandom, $urandom};
            in_carry  = {$urandom, $urandom};
            in_tag    = 8'(sent);
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                chk("rnd_hold_result", out_result, prev_res);
                chk("rnd_hold_tag", {56'b0, out_tag}, {56'b0, prev_tag});
            end
            if (out_valid && out_ready) begin
                if (q_res.size() == 0) begin
                    chk("rnd_extra_output", 64'd1, 64'd0);
                end else begin
                    e  = q_res.pop_front();
                    et = q_tag.pop_front();
                    chk("rnd_result", {out_cout, out_result}, e[63:0] |
                        (64'(e[64]) << 63) & 64'h0);
                    chk("rnd_cout", {63'b0, out_cout}, {63'b0, e[64]});
                    chk("rnd_tag", {56'b0, out_tag}, {56'b0, et});
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                q_res.push_back({1'b0, in_sum} + {1'b0, in_carry});
                q_tag.push_back(in_tag);
                sent++;
            end
            prev_stall = out_valid & ~out_ready;
            prev_res   = out_result;
            prev_tag   = out_tag;
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0;
        chk("rnd_received", 64'(got), 64'd300);
        chk("rnd_queue_empty", 64'(q_res.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
